uart_tx_multi: RTL and testbench

Parametrised multi-channel UART transmitter, the successor to the fixed three-pin transmitter in the top-level wrapper. Each channel accepts bytes over a valid/ready handshake and serialises them as 8-bit frames with configurable baud divider, parity and stop bits. Channels run independently in parallel, one TX pin each. The block sits between on-chip data sources and the `uio_out` pins.

---
 rtl/uart_tx_multi.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_multi.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_multi.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_multi
// Description : Multi-channel UART transmitter. Each channel takes a byte on
//               a valid/ready handshake and serialises it as start, 8 data
//               bits (LSB first), optional parity and 1 or 2 stop bits on
//               its own registered TX pin. Channels run fully independently.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_multi #(
    parameter int CHANNELS     = 3,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*CHANNELS-1:0] tx_data,
    input  logic [CHANNELS-1:0]   tx_valid,
    output logic [CHANNELS-1:0]   tx_ready,
    output logic [CHANNELS-1:0]   tx_pin,
    output logic [CHANNELS-1:0]   busy
);

    localparam int                  c_timer_w   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_timer_w-1:0] c_timer_max = c_timer_w'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          c_stop_last = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Reject unsupported configurations at elaboration.
    generate
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("uart_tx_multi: CHANNELS must be 1..8");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_multi: CLKS_PER_BIT must be >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_multi: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_multi: STOP_BITS must be 1 or 2");
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            state_t                r_state;
            state_t                w_state_next;
            logic [c_timer_w-1:0]  r_timer;
            logic [c_timer_w-1:0]  w_timer_next;
            logic [2:0]            r_idx;
            logic [2:0]            w_idx_next;
            logic [7:0]            r_shift;
            logic [7:0]            w_shift_next;
            logic                  r_par;
            logic                  w_par_next;
            logic                  r_pin;
            logic                  w_pin_next;
            logic [7:0]            w_byte;
            logic                  w_accept;
            logic                  w_bit_end;

            assign w_byte    = tx_data[8*gi +: 8];
            assign w_accept  = tx_valid[gi] && (r_state == S_IDLE);
            assign w_bit_end = (r_timer == c_timer_max);

            // State, timers, captured byte and the pin register; reset aborts any frame.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_idx   <= '0;
                    r_shift <= '0;
                    r_par   <= 1'b0;
                    r_pin   <= 1'b1;
                end else begin
                    r_state <= w_state_next;
                    r_timer <= w_timer_next;
                    r_idx   <= w_idx_next;
                    r_shift <= w_shift_next;
                    r_par   <= w_par_next;
                    r_pin   <= w_pin_next;
                end
            end

            // Next-state logic; the pin register follows the current state, so
            // each bit appears on the line one cycle after its state begins.
            always_comb begin
                w_state_next = r_state;
                w_timer_next = w_bit_end ? '0 : r_timer + 1'b1;
                w_idx_next   = r_idx;
                w_shift_next = r_shift;
                w_par_next   = r_par;
                w_pin_next   = 1'b1;

                case (r_state)
                    S_IDLE: begin
                        w_timer_next = '0;
                        w_idx_next   = '0;
                        w_pin_next   = 1'b1;
                        if (w_accept) begin
                            w_shift_next = w_byte;
                            w_par_next   = (PARITY == 2) ? ~(^w_byte) : ^w_byte;
                            w_state_next = S_START;
                        end
                    end
                    S_START: begin
                        w_pin_next = 1'b0;
                        if (w_bit_end) begin
                            w_idx_next   = '0;
                            w_state_next = S_DATA;
                        end
                    end
                    S_DATA: begin
                        w_pin_next = r_shift[0];
                        if (w_bit_end) begin
                            w_shift_next = {1'b0, r_shift[7:1]};
                            if (r_idx == 3'd7) begin
                                w_idx_next   = '0;
                                w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                w_idx_next = r_idx + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        w_pin_next = r_par;
                        if (w_bit_end) begin
                            w_idx_next   = '0;
                            w_state_next = S_STOP;
                        end
                    end
                    S_STOP: begin
                        w_pin_next = 1'b1;
                        if (w_bit_end) begin
                            if (r_idx == c_stop_last) begin
                                w_idx_next   = '0;
                                w_state_next = S_IDLE;
                            end else begin
                                w_idx_next = r_idx + 3'd1;
                            end
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_timer_next = '0;
                        w_idx_next   = '0;
                    end
                endcase
            end

            assign tx_ready[gi] = (r_state == S_IDLE);
            assign busy[gi]     = (r_state != S_IDLE);
            assign tx_pin[gi]   = r_pin;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_multi
// Description : Directed self-checking bench for uart_tx_multi. Three
//               instances cover no parity / 1 stop (3 channels), even
//               parity / 2 stops and odd parity / 1 stop, all at 4 clocks
//               per bit. Expected line levels come from a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [23:0] a_data  = '0;
    logic [2:0]  a_valid = '0;
    logic [2:0]  a_ready;
    logic [2:0]  a_pin;
    logic [2:0]  a_busy;

    logic [7:0]  b_data  = '0;
    logic [0:0]  b_valid = '0;
    logic [0:0]  b_ready;
    logic [0:0]  b_pin;
    logic [0:0]  b_busy;

    logic [7:0]  c_data  = '0;
    logic [0:0]  c_valid = '0;
    logic [0:0]  c_ready;
    logic [0:0]  c_pin;
    logic [0:0]  c_busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    uart_tx_multi #(.CHANNELS(3), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(rst), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx_pin(a_pin), .busy(a_busy)
    );

    uart_tx_multi #(.CHANNELS(1), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_b (
        .clk(clk), .reset(rst), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx_pin(b_pin), .busy(b_busy)
    );

    uart_tx_multi #(.CHANNELS(1), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_c (
        .clk(clk), .reset(rst), .tx_data(c_data), .tx_valid(c_valid),
        .tx_ready(c_ready), .tx_pin(c_pin), .busy(c_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected line level n cycles after the accepting edge (4 clocks per bit).
    function automatic logic exp_pin(input logic [7:0] d, input int pmode, input int n);
        int b;
        if (n <= 0) return 1'b1;
        b = (n - 1) / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pmode != 0 && b == 9) return (pmode == 1) ? ^d : ~(^d);
        return 1'b1;
    endfunction

    function automatic logic get_pin(input int inst, input int ch);
        case (inst)
            0:       return a_pin[ch];
            1:       return b_pin[0];
            default: return c_pin[0];
        endcase
    endfunction

    function automatic logic get_ready(input int inst, input int ch);
        case (inst)
            0:       return a_ready[ch];
            1:       return b_ready[0];
            default: return c_ready[0];
        endcase
    endfunction

    task automatic drive(input int inst, input int ch, input logic v, input logic [7:0] d);
        case (inst)
            0: begin a_valid[ch] = v; a_data[8*ch +: 8] = d; end
            1: begin b_valid[0] = v; b_data = d; end
            default: begin c_valid[0] = v; c_data = d; end
        endcase
    endtask

    // Send d0 (and d1 back-to-back with valid held when nframes==2); tx_data is
    // switched to d1 right after the first capture, so single frames also show
    // that the captured byte is what goes out.
    task automatic run_frames(input int inst, input int ch, input logic [7:0] d0,
                              input logic [7:0] d1, input int nframes, input string tag);
        int f_len;
        int f;
        int m;
        f_len = (inst == 0) ? 40 : (inst == 1) ? 48 : 44;
        drive(inst, ch, 1'b1, d0);
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n < nframes * (f_len + 1); n++) begin
            f = n / (f_len + 1);
            m = n % (f_len + 1);
            if (n == 0) drive(inst, ch, (nframes > 1), d1);
            if (nframes > 1 && n == f_len + 1) drive(inst, ch, 1'b0, d1);
            chk($sformatf("%s pin n=%0d", tag, n), 8'(get_pin(inst, ch)),
                8'(exp_pin((f == 0) ? d0 : d1, inst, m)));
            chk($sformatf("%s ready n=%0d", tag, n), 8'(get_ready(inst, ch)), 8'(m == f_len));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] w_bytes [3];
        logic       e_pin;
        logic       e_rdy;

        // Reset state, during and just after reset.
        repeat (2) @(negedge clk);
        chk("rst a_pin", 8'(a_pin), 8'h07);
        chk("rst a_ready", 8'(a_ready), 8'h07);
        chk("rst a_busy", 8'(a_busy), 8'h00);
        chk("rst b_pin", 8'(b_pin), 8'h01);
        chk("rst c_ready", 8'(c_ready), 8'h01);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst a_pin", 8'(a_pin), 8'h07);
        chk("post-rst b_busy", 8'(b_busy), 8'h00);

        // Single 0x55 frame on channel 0, data changed after capture.
        run_frames(0, 0, 8'h55, 8'hAA, 1, "a55");

        // Three channels accepted together; channel 1 re-requests 7 cycles in.
        w_bytes[0] = 8'hA5;
        w_bytes[1] = 8'h3C;
        w_bytes[2] = 8'hFF;
        a_data  = {w_bytes[2], w_bytes[1], w_bytes[0]};
        a_valid = 3'b111;
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n <= 81; n++) begin
            if (n == 0) a_valid = 3'b000;
            if (n == 7) begin
                a_data[15:8] = 8'h5A;
                a_valid[1]   = 1'b1;
            end
            if (n == 41) a_valid[1] = 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                if (ch == 1) begin
                    e_pin = (n <= 40) ? exp_pin(w_bytes[1], 0, n) : exp_pin(8'h5A, 0, n - 41);
                    e_rdy = (n == 40) || (n == 81);
                end else begin
                    e_pin = exp_pin(w_bytes[ch], 0, n);
                    e_rdy = (n >= 40);
                end
                chk($sformatf("multi ch%0d pin n=%0d", ch, n), 8'(a_pin[ch]), 8'(e_pin));
                chk($sformatf("multi ch%0d ready n=%0d", ch, n), 8'(a_ready[ch]), 8'(e_rdy));
            end
            @(negedge clk);
        end

        // Reset in the middle of a data bit on channel 0.
        drive(0, 0, 1'b1, 8'hF0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 1'b0, 8'hF0);
        repeat (14) @(negedge clk);
        chk("pre-abort pin", 8'(a_pin[0]), 8'h00);
        chk("pre-abort busy", 8'(a_busy[0]), 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("async abort pin", 8'(a_pin[0]), 8'h01);
        chk("async abort ready", 8'(a_ready[0]), 8'h01);
        chk("async abort busy", 8'(a_busy[0]), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk($sformatf("idle after rst pin n=%0d", n), 8'(a_pin[0]), 8'h01);
            chk($sformatf("idle after rst ready n=%0d", n), 8'(a_ready[0]), 8'h01);
        end
        run_frames(0, 0, 8'h3C, 8'h3C, 1, "a3c_after_rst");

        // Even parity, two stop bits: single frame then back-to-back pair.
        run_frames(1, 0, 8'h07, 8'h07, 1, "b07");
        run_frames(1, 0, 8'h01, 8'h80, 2, "b_btb");

        // Odd parity, one stop bit.
        run_frames(2, 0, 8'h00, 8'h00, 1, "c00");
        run_frames(2, 0, 8'h01, 8'h01, 1, "c01");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
